tc_result_drain: RTL and testbench

- Output-side counterpart of the tensor-core psum block.
- Captures the complete M x N result matrix when the core strobes its result valid.
- Streams the matrix out as fixed-width beats over a valid/ready handshake, with row/column sideband, last flag and a done pulse.
- Sits between the tensor core result bus and the downstream writeback/DMA path.

---
 rtl/tc_result_drain.sv | 203 ++++++++++++++++++++
 tb/tb_tc_result_drain.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tc_result_drain
// Description : Captures a complete M x N tensor-core result matrix on a
//               one-cycle res_valid strobe and streams it out as BEAT-element
//               beats over a valid/ready handshake, with row/column sideband,
//               a last flag and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   res_valid    in   strobe: res_in holds a complete matrix
//   res_in       in   flat matrix, C[r][c] at [(r*N+c)*DW_OUT +: DW_OUT]
//   busy         out  high while a matrix is streaming
//   m_valid      out  output beat valid
//   m_ready      in   downstream accepts the beat
//   m_data       out  beat, element i at [i*DW_OUT +: DW_OUT]
//   m_row        out  row of element 0 of the beat
//   m_col        out  column of element 0 of the beat
//   m_last       out  final beat of the matrix
//   done         out  one-cycle pulse after the final handshake
//   overrun      out  sticky: a res_valid strobe arrived while not idle
//   overrun_clr  in   clears overrun (a same-cycle drop wins)
// ----------------------------------------------------------------------------
// Build option
//   TC_DRAIN_COLMAJOR_EN : stream the matrix column-major (element i of a
//                          beat is C[row+i][col]); requires M % BEAT == 0.
//                          Undefined: row-major only.
// ============================================================================
module tc_result_drain #(
    parameter int M      = 32,
    parameter int N      = 32,
    parameter int DW_OUT = 8,
    parameter int BEAT   = 4,
    parameter int DW_POS = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     res_valid,
    input  logic [M*N*DW_OUT-1:0]    res_in,
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [BEAT*DW_OUT-1:0]   m_data,
    output logic [DW_POS-1:0]        m_row,
    output logic [DW_POS-1:0]        m_col,
    output logic                     m_last,
    output logic                     done,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int NB     = (M * N) / BEAT;
    localparam int BW     = (NB > 1) ? $clog2(NB) : 1;
    localparam int BEAT_W = BEAT * DW_OUT;

    localparam logic [BW-1:0]     c_beat_last = BW'(NB - 1);
    localparam logic [BW-1:0]     c_beat_one  = BW'(1);
    localparam logic [DW_POS-1:0] c_pos_one   = DW_POS'(1);
    localparam logic [DW_POS-1:0] c_pos_step  = DW_POS'(BEAT);
`ifdef TC_DRAIN_COLMAJOR_EN
    localparam logic [DW_POS-1:0] c_row_wrap  = DW_POS'(M - BEAT);
`else
    localparam logic [DW_POS-1:0] c_col_wrap  = DW_POS'(N - BEAT);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [M*N*DW_OUT-1:0]   r_buf;
    logic [BW-1:0]           r_beat;
    logic [DW_POS-1:0]       r_row;
    logic [DW_POS-1:0]       r_col;
    logic                    r_overrun;
    logic                    w_capture;
    logic                    w_drop;
    logic                    w_hs;
    logic                    w_last_beat;
    logic [BEAT_W-1:0]       w_data;

    assign w_capture   = (r_state == S_IDLE) && res_valid;
    assign w_drop      = (r_state != S_IDLE) && res_valid;
    assign w_hs        = (r_state == S_STREAM) && m_ready;
    assign w_last_beat = (r_beat == c_beat_last);
    assign overrun     = r_overrun;

    // Beat payload selection from the held matrix.
`ifdef TC_DRAIN_COLMAJOR_EN
    // Column-major: BEAT consecutive rows of one column.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < BEAT; i++) begin
            w_data[i*DW_OUT +: DW_OUT] =
                r_buf[((int'(r_row) + i) * N + int'(r_col)) * DW_OUT +: DW_OUT];
        end
    end
`else
    // Row-major: beat b is simply the b-th contiguous BEAT-element slice.
    assign w_data = r_buf[int'(r_beat) * BEAT_W +: BEAT_W];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are gated by state so everything idles at zero.
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_row   = '0;
        m_col   = '0;
        m_data  = '0;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (res_valid) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_last  = w_last_beat;
                m_row   = r_row;
                m_col   = r_col;
                m_data  = w_data;
                if (m_ready && w_last_beat) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture buffer: no reset, contents only matter once captured.
    always_ff @(posedge clk) begin
        if (w_capture && !reset) begin
            r_buf <= res_in;
        end
    end

    // Beat counter and sideband position; the counter parks at NB-1 after
    // the final handshake and is cleared by the next capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_beat <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_hs && !w_last_beat) begin
                r_beat <= r_beat + c_beat_one;
`ifdef TC_DRAIN_COLMAJOR_EN
                if (r_row == c_row_wrap) begin
                    r_row <= '0;
                    r_col <= r_col + c_pos_one;
                end else begin
                    r_row <= r_row + c_pos_step;
                end
`else
                if (r_col == c_col_wrap) begin
                    r_col <= '0;
                    r_row <= r_row + c_pos_one;
                end else begin
                    r_col <= r_col + c_pos_step;
                end
`endif
            end

            // A dropped strobe takes priority over a same-cycle clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tc_result_drain
// Description : Self-checking bench for tc_result_drain with a matrix-level
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_result_drain;

    localparam int M    = 32;
    localparam int N    = 32;
    localparam int DW   = 8;
    localparam int BEAT = 4;
    localparam int DWP  = 6;
    localparam int NB   = (M * N) / BEAT;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  res_valid = 1'b0;
    logic [M*N*DW-1:0]     res_in = '0;
    logic                  m_ready = 1'b0;
    logic                  overrun_clr = 1'b0;
    logic                  busy;
    logic                  m_valid;
    logic [BEAT*DW-1:0]    m_data;
    logic [DWP-1:0]        m_row;
    logic [DWP-1:0]        m_col;
    logic                  m_last;
    logic                  done;
    logic                  overrun;

    tc_result_drain #(
        .M(M), .N(N), .DW_OUT(DW), .BEAT(BEAT), .DW_POS(DWP)
    ) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_in(res_in),
        .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_last(m_last), .done(done),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Test matrices: kind 0 is C[r][c] = (r*32+c) mod 256.
    function automatic logic [M*N*DW-1:0] pattern(input int kind);
        logic [M*N*DW-1:0] p;
        int v;
        p = '0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0:       v = (r * 32 + c) % 256;
                    1:       v = (r * 7 + c * 13 + 5) % 256;
                    default: v = (r + c * 3 + 77) % 256;
                endcase
                p[(r*N+c)*DW +: DW] = 8'(v);
            end
        end
        return p;
    endfunction

    // ---------------- reference model ----------------
    int        mphase = 0;   // 0 idle, 1 streaming, 2 done pulse
    int        mb = 0;
    bit        movr = 1'b0;
    logic [7:0] mmat [M][N];

    function automatic int mrow(input int b);
`ifdef TC_DRAIN_COLMAJOR_EN
        return (b % (M / BEAT)) * BEAT;
`else
        return b / (N / BEAT);
`endif
    endfunction

    function automatic int mcol(input int b);
`ifdef TC_DRAIN_COLMAJOR_EN
        return b / (M / BEAT);
`else
        return (b % (N / BEAT)) * BEAT;
`endif
    endfunction

    function automatic logic [31:0] mdata(input int b);
        logic [31:0] d;
        for (int i = 0; i < BEAT; i++) begin
`ifdef TC_DRAIN_COLMAJOR_EN
            d[i*8 +: 8] = mmat[mrow(b) + i][mcol(b)];
`else
            d[i*8 +: 8] = mmat[mrow(b)][mcol(b) + i];
`endif
        end
        return d;
    endfunction

    bit          chk_en = 1'b0;
    bit          rec = 1'b0;
    int          rec_base = 0;
    int          hs_count = 0;
    int          done_count = 0;
    int          last_hs_count = 0;
    logic [31:0] rx_data [NB];
    int          rx_row [NB];
    int          rx_col [NB];

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", m_valid, (mphase == 1));
            check("busy", busy, (mphase == 1));
            check("done", done, (mphase == 2));
            check("m_last", m_last, (mphase == 1 && mb == NB - 1));
            check("overrun", overrun, movr);
            check("m_row", m_row, (mphase == 1) ? mrow(mb) : 0);
            check("m_col", m_col, (mphase == 1) ? mcol(mb) : 0);
            check("m_data", m_data, (mphase == 1) ? mdata(mb) : 32'h0);

            if (!reset && m_valid && m_ready) begin
                hs_count <= hs_count + 1;
                if (m_last) last_hs_count <= last_hs_count + 1;
                if (rec && (hs_count - rec_base) < NB && hs_count >= rec_base) begin
                    rx_data[hs_count - rec_base] <= m_data;
                    rx_row[hs_count - rec_base]  <= int'(m_row);
                    rx_col[hs_count - rec_base]  <= int'(m_col);
                end
            end
            if (!reset && done) done_count <= done_count + 1;

            if (reset) begin
                mphase <= 0;
                mb     <= 0;
                movr   <= 1'b0;
            end else begin
                if (res_valid && mphase != 0) movr <= 1'b1;
                else if (overrun_clr)         movr <= 1'b0;
                case (mphase)
                    0: if (res_valid) begin
                        for (int r = 0; r < M; r++)
                            for (int c = 0; c < N; c++)
                                mmat[r][c] <= res_in[(r*N+c)*DW +: DW];
                        mb     <= 0;
                        mphase <= 1;
                    end
                    1: if (m_ready) begin
                        if (mb == NB - 1) mphase <= 2;
                        else              mb <= mb + 1;
                    end
                    default: mphase <= 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rnd = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) m_ready = 1'($urandom_range(0, 1));
    endtask

    // Strobe a matrix, then scramble res_in so late changes are exercised.
    task automatic strobe(input int kind);
        res_in    = pattern(kind);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        res_in    = pattern(9);
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check(nm, done, 1'b1);
    endtask

    task automatic wait_hs(input string nm, input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 3000) begin
            tick();
            n++;
        end
        check(nm, (hs_count >= target), 1'b1);
    endtask

    logic [31:0] ref_data [NB];
    int          ref_row [NB];
    int          ref_col [NB];

    initial begin
        int cyc;
        int base_hs;
        int base_done;
        int base_last;
        int nbad;

        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_m_data", m_data, 32'h0);

        // ---- T1: full-rate stream ----
        m_ready   = 1'b1;
        base_hs   = hs_count;
        base_done = done_count;
        base_last = last_hs_count;
        rec_base  = hs_count;
        rec       = 1'b1;
        strobe(0);
        check("t1_latency_valid", m_valid, 1'b1);
        check("t1_first_row", m_row, 6'd0);
        check("t1_first_col", m_col, 6'd0);
`ifdef TC_DRAIN_COLMAJOR_EN
        check("t1_first_data", m_data, 32'h60402000);
`else
        check("t1_first_data", m_data, 32'h03020100);
`endif
        wait_done("t1_done", cyc);
        check("t1_cycles", cyc, 256);
        repeat (2) tick();
        rec = 1'b0;
        check("t1_handshakes", hs_count - base_hs, 256);
        check("t1_done_pulses", done_count - base_done, 1);
        check("t1_last_count", last_hs_count - base_last, 1);
`ifdef TC_DRAIN_COLMAJOR_EN
        check("t1_b8_row", rx_row[8], 0);
        check("t1_b8_col", rx_col[8], 1);
        check("t1_b255_row", rx_row[255], 28);
        check("t1_b255_col", rx_col[255], 31);
        check("t1_b255_data", rx_data[255], 32'hFFDFBF9F);
`else
        check("t1_b8_row", rx_row[8], 1);
        check("t1_b8_col", rx_col[8], 0);
        check("t1_b8_data", rx_data[8], 32'h23222120);
        check("t1_b255_row", rx_row[255], 31);
        check("t1_b255_col", rx_col[255], 28);
        check("t1_b255_data", rx_data[255], 32'hFFFEFDFC);
`endif
        for (int i = 0; i < NB; i++) begin
            ref_data[i] = rx_data[i];
            ref_row[i]  = rx_row[i];
            ref_col[i]  = rx_col[i];
        end

        // ---- T2: random back-pressure, same matrix ----
        base_hs  = hs_count;
        rec_base = hs_count;
        rec      = 1'b1;
        rnd      = 1'b1;
        strobe(0);
        wait_done("t2_done", cyc);
        rnd     = 1'b0;
        m_ready = 1'b1;
        tick();
        rec  = 1'b0;
        nbad = 0;
        for (int i = 0; i < NB; i++) begin
            if (rx_data[i] !== ref_data[i] || rx_row[i] != ref_row[i] || rx_col[i] != ref_col[i])
                nbad++;
        end
        check("t2_sequence_mismatches", nbad, 0);
        check("t2_handshakes", hs_count - base_hs, 256);

        // ---- T3: overrun while streaming ----
        base_hs = hs_count;
        strobe(0);
        wait_hs("t3_reach_b10", base_hs + 10);
        res_in    = pattern(1);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("t3_overrun_set", overrun, 1'b1);
        wait_done("t3_done", cyc);
        check("t3_overrun_sticky", overrun, 1'b1);
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t3_overrun_cleared", overrun, 1'b0);
        base_hs = hs_count;
        strobe(1);
        wait_hs("t3_reach_b5", base_hs + 5);
        res_valid   = 1'b1;
        overrun_clr = 1'b1;
        tick();
        res_valid   = 1'b0;
        overrun_clr = 1'b0;
        check("t3_set_wins", overrun, 1'b1);
        wait_done("t3_done2", cyc);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t3_overrun_cleared2", overrun, 1'b0);

        // ---- T4: reset mid-stream ----
        base_hs = hs_count;
        strobe(0);
        wait_hs("t4_reach_b100", base_hs + 100);
        base_done = done_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_valid_after_reset", m_valid, 1'b0);
        check("t4_busy_after_reset", busy, 1'b0);
        check("t4_last_after_reset", m_last, 1'b0);
        repeat (3) tick();
        check("t4_no_done", done_count - base_done, 0);
        strobe(1);
        check("t4_restart_valid", m_valid, 1'b1);
        check("t4_restart_row", m_row, 6'd0);
        check("t4_restart_col", m_col, 6'd0);
        wait_done("t4_done", cyc);

        // ---- T5: back-to-back matrices ----
        tick();
        strobe(0);
        wait_done("t5_done_a", cyc);
        tick();
        strobe(1);
        check("t5_second_accepted", m_valid, 1'b1);
        check("t5_no_overrun", overrun, 1'b0);
        wait_done("t5_done_b", cyc);
        check("t5_no_overrun_end", overrun, 1'b0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
